// File: rtl/branch_pred_ctrl_if.sv
// Pipeline <-> branch predictor bus: the IF-stage lookup, the EX-stage resolve,
// and the flush/redirect response. The pipeline side is the master; the
// predictor is the slave.
//
// Handshake semantics: there is no ready/backpressure. if_valid qualifies the
// IF lookup and pred_taken answers it in the same cycle. ex_valid & ~ex_stall
// qualifies an EX resolve. flush/redirect_pc answer that resolve in the same
// cycle and take effect at the next clock edge.
interface branch_pred_ctrl_if #(
  parameter int PC_W = 16
);
  logic            if_valid;
  logic [PC_W-1:0] if_pc;
  logic [4:0]      if_op;
  logic            pred_taken;
  logic            ex_valid;
  logic            ex_stall;
  logic [4:0]      ex_op;
  logic [PC_W-1:0] ex_pc;
  logic            ex_pred;
  logic            ex_taken;
  logic [PC_W-1:0] ex_target;
  logic            flush;
  logic [PC_W-1:0] redirect_pc;

  modport master (
    output if_valid, if_pc, if_op, ex_valid, ex_stall, ex_op, ex_pc,
           ex_pred, ex_taken, ex_target,
    input  pred_taken, flush, redirect_pc
  );

  modport slave (
    input  if_valid, if_pc, if_op, ex_valid, ex_stall, ex_op, ex_pc,
           ex_pred, ex_taken, ex_target,
    output pred_taken, flush, redirect_pc
  );
endinterface

// File: rtl/branch_pred_ctrl.sv
// Branch predictor and misprediction-recovery controller.
// A table of 2-bit saturating counters, indexed by pc[IDX_W:1], predicts
// conditional branches (op 01100..01111) in IF. EX resolves each branch;
// a mismatch raises flush and supplies the corrected fetch PC. One RECOVER
// cycle follows every flush while the refetched instruction enters IF.
// Optional build macro BP_STATS_EN adds saturating branch/mispredict counters.
module branch_pred_ctrl #(
  parameter int IDX_W = 4,
  parameter int PC_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  branch_pred_ctrl_if.slave  bp,
  output logic               dbg_state_o
`ifdef BP_STATS_EN
  ,
  output logic [15:0]        stat_branches,
  output logic [15:0]        stat_mispred
`endif
);

  typedef enum logic {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } state_t;

  localparam int N_ENT = 2 ** IDX_W;

  state_t          state_q;
  logic [1:0]      ctr_q [N_ENT];

  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  logic [1:0]       ex_ctr;
  logic [1:0]       ex_ctr_d;
  logic             upd;
  logic             mispredict;
  logic             unused_pc_bits;

  function automatic logic is_branch(input logic [4:0] op);
    return (op[4:2] == 3'b011);
  endfunction

  assign if_idx = bp.if_pc[IDX_W:1];
  assign ex_idx = bp.ex_pc[IDX_W:1];
  assign ex_ctr = ctr_q[ex_idx];

  // Bits of the IF PC that never reach the table index.
  assign unused_pc_bits = ^{bp.if_pc[PC_W-1:IDX_W+1], bp.if_pc[0]};

  // In RECOVER, EX holds a bubble, so nothing is resolved from it.
  assign upd        = ~rst & (state_q == RUN) & bp.ex_valid & ~bp.ex_stall
                      & is_branch(bp.ex_op);
  assign mispredict = upd & (bp.ex_taken != bp.ex_pred);

  // Prediction reads the registered counter, so a same-cycle update is not visible.
  assign bp.pred_taken = ~rst & bp.if_valid & is_branch(bp.if_op)
                         & ctr_q[if_idx][1] & (state_q == RUN);

  assign bp.flush       = mispredict;
  assign bp.redirect_pc = !mispredict  ? '0 :
                          bp.ex_taken  ? bp.ex_target :
                                         bp.ex_pc + PC_W'(2);

  assign dbg_state_o = (state_q == RECOVER);

  // Saturating increment/decrement of the resolved branch's counter.
  always_comb begin
    ex_ctr_d = ex_ctr;
    if (bp.ex_taken) begin
      if (ex_ctr != 2'b11) ex_ctr_d = ex_ctr + 2'b01;
    end else begin
      if (ex_ctr != 2'b00) ex_ctr_d = ex_ctr - 2'b01;
    end
  end

  // Counter table: reset to weakly not-taken, one entry written per resolve.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_ENT; i++) ctr_q[i] <= 2'b01;
    end else if (upd) begin
      ctr_q[ex_idx] <= ex_ctr_d;
    end
  end

  // Recovery FSM: a mispredict costs exactly one RECOVER cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      case (state_q)
        RUN:     if (mispredict) state_q <= RECOVER;
        RECOVER: state_q <= RUN;
        default: state_q <= RUN;
      endcase
    end
  end

  // EX must hold a bubble during RECOVER; a valid instruction there is ignored.
  a_no_ex_in_recover: assert property (
    @(posedge clk) disable iff (rst) (state_q == RECOVER) |-> !bp.ex_valid
  );

`ifdef BP_STATS_EN
  // Resolve and mispredict counters, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches <= '0;
      stat_mispred  <= '0;
    end else begin
      if (upd && stat_branches != 16'hFFFF) stat_branches <= stat_branches + 16'd1;
      if (mispredict && stat_mispred != 16'hFFFF) stat_mispred <= stat_mispred + 16'd1;
    end
  end
`endif

endmodule

// File: doc/branch_pred_ctrl.md
Name: branch_pred_ctrl

Overview:
Branch prediction and misprediction-recovery controller for the 5-stage pipeline.
- Holds a table of 2-bit saturating counters indexed by low PC bits and predicts BEQZ/BNEZ/BLTZ/BGEZ in IF.
- Compares each prediction against the actual outcome resolved in EX by the branch-condition logic.
- On mismatch, drives the pipeline flush and the corrected fetch PC.

Parameters:
IDX_W, 4, table index width (2^IDX_W entries, indexed by pc[IDX_W:1])
PC_W, 16, PC width

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
if_valid  in  1  IF stage holds a valid instruction
if_pc  in  PC_W  PC of IF instruction
if_op  in  5  opcode field of IF instruction
pred_taken  out  1  predict taken for IF instruction
ex_valid  in  1  EX stage holds a valid, non-squashed instruction
ex_stall  in  1  EX held this cycle (hazard stall)
ex_op  in  5  opcode of EX instruction
ex_pc  in  PC_W  PC of EX instruction
ex_pred  in  1  pred_taken value carried down the pipe with the EX instruction
ex_taken  in  1  actual branch outcome from branch-condition logic
ex_target  in  PC_W  computed branch target
flush  out  1  squash IF/ID and ID/EX at next edge
redirect_pc  out  PC_W  fetch PC to load when flush=1

Behaviour:
- Conditional branch means op in 5'b01100..5'b01111. All other ops are non-branch.
- Reset (rst high at posedge): every counter set to 2'b01 (weakly not-taken), state set to RUN. During the reset cycle pred_taken=0, flush=0, redirect_pc=0. A reset mid-operation discards all history and any pending recovery.
- Prediction (combinational, 0-cycle): pred_taken = if_valid & is_branch(if_op) & ctr[if_pc[IDX_W:1]][1] & (state==RUN).
- Resolve: upd = ex_valid & ~ex_stall & is_branch(ex_op).
  - mispredict = upd & (ex_taken != ex_pred).
- Counter update at posedge when upd:
  - ex_taken=1: counter increments, saturating at 3.
  - ex_taken=0: counter decrements, saturating at 0.
  - Index is ex_pc[IDX_W:1]. Exactly one entry is written per cycle.
- Read/write same index in same cycle: the prediction uses the pre-update value; there is no bypass.
- flush = mispredict (combinational).
  - redirect_pc = ex_taken ? ex_target : ex_pc + 2, computed modulo 2^PC_W so that 0xFFFE+2 wraps to 0x0000.
  - When flush=0, redirect_pc is driven to 0.
- FSM, two states:
  - RUN: a mispredict moves the FSM to RECOVER.
  - RECOVER: lasts exactly one cycle, then returns to RUN. pred_taken is forced 0 while the refetch at redirect_pc enters IF; no counter update or flush is generated from EX, since EX holds a bubble.
  - ex_valid=1 in RECOVER is a protocol violation (caught by assertion); the RTL ignores it.
- Stall: when ex_stall=1, there is no update and no flush; the same branch is re-evaluated when the stall releases.
- Non-branch ops in EX never update or flush, regardless of ex_pred.

Optional Feature:
Macro BP_STATS_EN.
- Defined:
  - Adds outputs stat_branches[15:0] (count of cycles with upd=1) and stat_mispred[15:0] (count of cycles with mispredict=1).
  - Both counters saturate at 16'hFFFF and are cleared by rst.
- Undefined: the ports and counters are absent. Prediction and recovery behaviour is identical either way.

Test Plan:
- Reset, then IF BEQZ at if_pc=0x0010 -> pred_taken=0 (counter 01); EX resolves ex_taken=1, ex_pred=0, ex_target=0x0040 -> flush=1, redirect_pc=0x0040 same cycle; next cycle pred_taken=0 (RECOVER); counter[8]=2.
- Two more taken resolves at pc 0x0010, then a third -> counter saturates at 3; IF at 0x0010 gives pred_taken=1; a not-taken resolve with ex_pred=1 -> flush=1, redirect_pc=0x0012, counter=2.
- ex_pc=0xFFFE, ex_pred=1, ex_taken=0 -> redirect_pc=0x0000.
- ex_stall=1 with mispredicting branch for 3 cycles -> flush=0 and counter unchanged throughout; flush=1 on the cycle ex_stall drops.
- Same-index read/write: IF and EX both at pc 0x0020, counter=1, ex_taken=1 -> pred_taken=0 that cycle, pred_taken=1 next RUN cycle.
- rst asserted during RECOVER -> state RUN, all counters 01, flush=0; with BP_STATS_EN, 5 branches (2 mispredicted) -> stat_branches=5, stat_mispred=2, and rst clears both to 0.
